// File: rtl/elevador_pkg.sv
// +----------------------------------------------------------------------------+
// | elevador_pkg: shared state enum and encodings for the 3-floor car plant.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package elevador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // init_sel: where the car sits when reset is applied
  localparam logic [1:0] c_init_f1   = 2'd0;
  localparam logic [1:0] c_init_f2   = 2'd1;
  localparam logic [1:0] c_init_f3   = 2'd2;
  localparam logic [1:0] c_init_mid  = 2'd3;

  // inj_sel: sensor forced high while inj_en is set
  localparam logic [1:0] c_inj_f1    = 2'd0;
  localparam logic [1:0] c_inj_f2    = 2'd1;
  localparam logic [1:0] c_inj_f3    = 2'd2;
  localparam logic [1:0] c_inj_none  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/elevador_planta_sensores.sv
// +----------------------------------------------------------------------------+
// | elevador_planta_sensores: floor sensor decode from car position, with      |
// | optional forcing enabled by macro ELEVADOR_PLANTA_FAULT_INJ_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module elevador_planta_sensores
  import elevador_pkg::*;
#(
  parameter int TRAVEL_CYC = 8,
  parameter int PW         = $clog2(2*TRAVEL_CYC+1)
) (
  input  logic [PW-1:0] pos,
  input  logic          inj_en,
  input  logic [1:0]    inj_sel,
  output logic          f1,
  output logic          f2,
  output logic          f3
);

  localparam logic [PW-1:0] c_pos_f2 = PW'(TRAVEL_CYC);
  localparam logic [PW-1:0] c_pos_f3 = PW'(2*TRAVEL_CYC);

  logic [2:0] w_inj;

`ifdef ELEVADOR_PLANTA_FAULT_INJ_EN
  assign w_inj[0] = inj_en && (inj_sel == c_inj_f1);
  assign w_inj[1] = inj_en && (inj_sel == c_inj_f2);
  assign w_inj[2] = inj_en && (inj_sel == c_inj_f3);
`else
  // Ports stay for a stable interface; the sink keeps lint quiet.
  logic w_unused;
  assign w_unused = &{1'b0, inj_en, inj_sel};
  assign w_inj    = 3'b000;
`endif

  assign f1 = (pos == '0)       | w_inj[0];
  assign f2 = (pos == c_pos_f2) | w_inj[1];
  assign f3 = (pos == c_pos_f3) | w_inj[2];

endmodule

`default_nettype wire

// File: rtl/elevador_planta_3pisos.sv
// +----------------------------------------------------------------------------+
// | elevador_planta_3pisos: 3-floor elevator car plant model (position counter,|
// | motor FSM, sticky errors). Optional macro ELEVADOR_PLANTA_FAULT_INJ_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module elevador_planta_3pisos
  import elevador_pkg::*;
#(
  parameter int  TRAVEL_CYC = 8,
  localparam int PW         = $clog2(2*TRAVEL_CYC+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    init_sel,
  input  logic          mup,
  input  logic          mdw,
  input  logic          inj_en,
  input  logic [1:0]    inj_sel,
  output logic          f1,
  output logic          f2,
  output logic          f3,
  output logic [PW-1:0] pos,
  output logic          moving,
  output logic          err_both,
  output logic          err_limit
);

  localparam logic [PW-1:0] c_pos_max = PW'(2*TRAVEL_CYC);
  localparam logic [PW-1:0] c_one     = PW'(1);

  state_t        r_state;
  logic [PW-1:0] r_pos;
  logic          r_moving;
  logic          r_err_both;
  logic          r_err_limit;
  logic [PW-1:0] w_init_pos;

  always_comb begin
    w_init_pos = '0;
    case (init_sel)
      c_init_f1:  w_init_pos = '0;
      c_init_f2:  w_init_pos = PW'(TRAVEL_CYC);
      c_init_f3:  w_init_pos = c_pos_max;
      default:    w_init_pos = PW'(TRAVEL_CYC/2);
    endcase
  end

  // Position moves on the same edge that the FSM enters UP/DOWN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pos       <= w_init_pos;
      r_moving    <= 1'b0;
      r_err_both  <= 1'b0;
      r_err_limit <= 1'b0;
    end else if (r_state == FAULT) begin
      r_moving <= 1'b0;
    end else begin
      case ({mup, mdw})
        2'b11: begin
          r_state    <= FAULT;
          r_err_both <= 1'b1;
          r_moving   <= 1'b0;
        end
        2'b10: begin
          if (r_pos == c_pos_max) begin
            r_state     <= FAULT;
            r_err_limit <= 1'b1;
            r_moving    <= 1'b0;
          end else begin
            r_state  <= UP;
            r_pos    <= r_pos + c_one;
            r_moving <= 1'b1;
          end
        end
        2'b01: begin
          if (r_pos == '0) begin
            r_state     <= FAULT;
            r_err_limit <= 1'b1;
            r_moving    <= 1'b0;
          end else begin
            r_state  <= DOWN;
            r_pos    <= r_pos - c_one;
            r_moving <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign pos       = r_pos;
  assign moving    = r_moving;
  assign err_both  = r_err_both;
  assign err_limit = r_err_limit;

  elevador_planta_sensores #(
    .TRAVEL_CYC (TRAVEL_CYC),
    .PW         (PW)
  ) u_sensores (
    .pos     (r_pos),
    .inj_en  (inj_en),
    .inj_sel (inj_sel),
    .f1      (f1),
    .f2      (f2),
    .f3      (f3)
  );

endmodule

`default_nettype wire
